// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: pipe-register control encodings and the
// hazard controller state type.
package pipe_pkg;

   // Pipe-register control encodings, also decoded by the pipe-register wrappers.
   localparam logic [1:0] CTR_NORMAL = 2'b00;  // load the next value
   localparam logic [1:0] CTR_STALL  = 2'b01;  // hold the current value
   localparam logic [1:0] CTR_BUBBLE = 2'b10;  // load zero (a NOP)

   typedef enum logic [1:0] {
      HZ_INIT  = 2'd0,
      HZ_RUN   = 2'd1,
      HZ_MWAIT = 2'd2,
      HZ_HALT  = 2'd3
   } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources from the pipeline stages and the
// per-register controls, PC strobes, state and counters back to them.
//
// There is no valid/ready pair on this bundle. Every signal is a level that is
// valid for the whole cycle and is sampled at posedge clk. The only
// request/completion pair is m_mem_req / m_mem_ready: the access finishes in the
// cycle where both are high, and every cycle with m_mem_req=1 and
// m_mem_ready=0 is a wait cycle.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   // Hazard sources.
   logic [4:0]       id_rs1_id;
   logic [4:0]       id_rs2_id;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic [4:0]       ex_rd_id;
   logic             ex_is_load;
   logic             ex_mispredict;
   logic             m_mem_req;
   logic             m_mem_ready;
   logic             wb_halt;

   // Pipeline control and observability.
   logic [1:0]       ctr_if_id;
   logic [1:0]       ctr_id_ex;
   logic [1:0]       ctr_ex_m;
   logic [1:0]       ctr_m_wb;
   logic             pc_hold;
   logic             pc_redirect;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             mem_timeout;

   // Pipeline side: drives the hazard sources and consumes the controls.
   modport master (
      output id_rs1_id, id_rs2_id, id_uses_rs1, id_uses_rs2, ex_rd_id,
             ex_is_load, ex_mispredict, m_mem_req, m_mem_ready, wb_halt,
      input  ctr_if_id, ctr_id_ex, ctr_ex_m, ctr_m_wb, pc_hold, pc_redirect,
             state, stall_cnt, flush_cnt, mem_timeout
   );

   // Controller side.
   modport slave (
      input  id_rs1_id, id_rs2_id, id_uses_rs1, id_uses_rs2, ex_rd_id,
             ex_is_load, ex_mispredict, m_mem_req, m_mem_ready, wb_halt,
      output ctr_if_id, ctr_id_ex, ctr_ex_m, ctr_m_wb, pc_hold, pc_redirect,
             state, stall_cnt, flush_cnt, mem_timeout
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping. clr wins over inc.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   // Count up, clear on request, hold once every bit is set.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the five-stage pipeline registers. Decodes memory-wait,
// mispredict and load-use hazards into per-register controls and PC strobes,
// and tracks stall/flush counts and a sticky memory-timeout flag.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input logic               clk,
   input logic               n_rst,
   pipe_hazard_ctrl_if.slave hz
);

   localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_t         state_q;
   hz_state_t         state_d;
   logic              mem_wait;
   logic              load_use;
   logic              rs1_hit;
   logic              rs2_hit;
   logic [1:0]        c_if_id;
   logic [1:0]        c_id_ex;
   logic [1:0]        c_ex_m;
   logic [1:0]        c_m_wb;
   logic              hold;
   logic              redirect;
   logic              stall_inc;
   logic              flush_inc;
   logic              wait_clr;
   logic              wait_inc;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_q;

   // A wait cycle is any cycle where M is accessing memory and it is not done.
   assign mem_wait = hz.m_mem_req & ~hz.m_mem_ready;

   // x0 is hard-wired to zero, so a load "writing" it never creates a hazard.
   assign rs1_hit  = hz.id_uses_rs1 & (hz.id_rs1_id == hz.ex_rd_id);
   assign rs2_hit  = hz.id_uses_rs2 & (hz.id_rs2_id == hz.ex_rd_id);
   assign load_use = hz.ex_is_load & (hz.ex_rd_id != 5'd0) & (rs1_hit | rs2_hit);

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= HZ_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, hazard-priority decode and counter strobes.
   always_comb begin
      state_d   = state_q;
      c_if_id   = CTR_NORMAL;
      c_id_ex   = CTR_NORMAL;
      c_ex_m    = CTR_NORMAL;
      c_m_wb    = CTR_NORMAL;
      hold      = 1'b0;
      redirect  = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      wait_clr  = 1'b0;
      wait_inc  = 1'b0;
      case (state_q)
         HZ_INIT: begin
            c_if_id = CTR_BUBBLE;
            c_id_ex = CTR_BUBBLE;
            c_ex_m  = CTR_BUBBLE;
            c_m_wb  = CTR_BUBBLE;
            hold    = 1'b1;
            state_d = HZ_RUN;
         end
         HZ_RUN, HZ_MWAIT: begin
            if (mem_wait) begin
               // EX is frozen here, so a pending mispredict is still
               // asserted when memory releases and is handled then.
               c_if_id   = CTR_STALL;
               c_id_ex   = CTR_STALL;
               c_ex_m    = CTR_STALL;
               c_m_wb    = CTR_BUBBLE;
               hold      = 1'b1;
               stall_inc = 1'b1;
            end else if (hz.ex_mispredict) begin
               c_if_id   = CTR_BUBBLE;
               c_id_ex   = CTR_BUBBLE;
               redirect  = 1'b1;
               flush_inc = 1'b1;
            end else if (load_use) begin
               c_if_id   = CTR_STALL;
               c_id_ex   = CTR_BUBBLE;
               hold      = 1'b1;
               stall_inc = 1'b1;
            end
            if (state_q == HZ_RUN) begin
               if (hz.wb_halt) begin
                  state_d = HZ_HALT;
               end else if (mem_wait) begin
                  state_d  = HZ_MWAIT;
                  wait_clr = 1'b1;
               end
            end else begin
               // Halt requests are not honoured until memory releases.
               wait_inc = (wait_cnt != WAIT_MAX);
               if (hz.m_mem_ready) begin
                  state_d = HZ_RUN;
               end
            end
         end
         HZ_HALT: begin
            c_if_id = CTR_STALL;
            c_id_ex = CTR_STALL;
            c_ex_m  = CTR_STALL;
            c_m_wb  = CTR_STALL;
            hold    = 1'b1;
         end
         default: begin
            state_d = HZ_INIT;
         end
      endcase
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (1'b0),
      .inc   (stall_inc),
      .q     (hz.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (1'b0),
      .inc   (flush_inc),
      .q     (hz.flush_cnt)
   );

   // Wait length is capped at MEM_TIMEOUT by gating inc above.
   sat_counter #(.W(WAIT_W)) u_wait_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (wait_clr),
      .inc   (wait_inc),
      .q     (wait_cnt)
   );

   // Sticky timeout: set on the same edge the wait count reaches MEM_TIMEOUT.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         timeout_q <= 1'b0;
      end else if (wait_inc && (wait_cnt == WAIT_LAST)) begin
         timeout_q <= 1'b1;
      end
   end

   assign hz.ctr_if_id   = c_if_id;
   assign hz.ctr_id_ex   = c_id_ex;
   assign hz.ctr_ex_m    = c_ex_m;
   assign hz.ctr_m_wb    = c_m_wb;
   assign hz.pc_hold     = hold;
   assign hz.pc_redirect = redirect;
   assign hz.state       = state_q;
   assign hz.mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and 4-bit counters.
// Driver tasks apply one cycle of inputs just after posedge and push the
// hand-computed expected outputs; a monitor pops and compares at negedge.
module tb_pipe_hazard_ctrl;

   localparam int TMO = 4;
   localparam int CW  = 4;
   localparam int VW  = 8 + 1 + 1 + 2 + CW + CW + 1;

   localparam logic [1:0] C_N = 2'b00;
   localparam logic [1:0] C_S = 2'b01;
   localparam logic [1:0] C_B = 2'b10;

   logic clk;
   logic n_rst;

   pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .hz    (hz)
   );

   logic [VW-1:0] exp_q[$];
   string         name_q[$];
   int            checks = 0;
   int            errors = 0;

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [VW-1:0] pack(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] c, input logic [1:0] d,
                                          input logic h, input logic r, input logic [1:0] st,
                                          input logic [CW-1:0] s, input logic [CW-1:0] f,
                                          input logic t);
      return {a, b, c, d, h, r, st, s, f, t};
   endfunction

   task automatic show(input string tag, input logic [VW-1:0] v, output string txt);
      txt = $sformatf("%s ctr=%b/%b/%b/%b hold=%b redir=%b state=%0d stall=%0d flush=%0d tmo=%b",
                      tag, v[VW-1 -: 2], v[VW-3 -: 2], v[VW-5 -: 2], v[VW-7 -: 2], v[VW-9],
                      v[VW-10], v[VW-11 -: 2], v[2*CW : CW+1], v[CW:1], v[0]);
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      logic [VW-1:0] e;
      logic [VW-1:0] a;
      string         nm;
      string         ta;
      string         te;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = pack(hz.ctr_if_id, hz.ctr_id_ex, hz.ctr_ex_m, hz.ctr_m_wb, hz.pc_hold,
                   hz.pc_redirect, hz.state, hz.stall_cnt, hz.flush_cnt, hz.mem_timeout);
         checks++;
         if (a !== e) begin
            errors++;
            show("actual", a, ta);
            show("required", e, te);
            $display("FAIL %s: %s ; %s", nm, ta, te);
         end
      end
   end

   task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic ld, input logic mp,
                        input logic req, input logic rdy, input logic halt);
      hz.id_rs1_id     = rs1;
      hz.id_uses_rs1   = u1;
      hz.id_rs2_id     = rs2;
      hz.id_uses_rs2   = u2;
      hz.ex_rd_id      = rd;
      hz.ex_is_load    = ld;
      hz.ex_mispredict = mp;
      hz.m_mem_req     = req;
      hz.m_mem_ready   = rdy;
      hz.wb_halt       = halt;
   endtask

   task automatic idle();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push_exp(input string nm, input logic [1:0] a, input logic [1:0] b,
                           input logic [1:0] c, input logic [1:0] d, input logic h,
                           input logic r, input logic [1:0] st, input logic [CW-1:0] s,
                           input logic [CW-1:0] f, input logic t);
      exp_q.push_back(pack(a, b, c, d, h, r, st, s, f, t));
      name_q.push_back(nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset with every hazard input active, held 3 cycles, then the INIT cycle.
   // Returns at the start of the first RUN cycle.
   task automatic do_reset();
      n_rst = 1'b0;
      drive(5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("reset_active", C_B, C_B, C_B, C_B, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0);
      tick();
      idle();
      tick();
      tick();
      n_rst = 1'b1;
      push_exp("init_cycle", C_B, C_B, C_B, C_B, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0);
      tick();
   endtask

   // Stimulus.
   initial begin
      n_rst = 1'b0;
      idle();
      @(posedge clk);
      #1;

      // Reset release and first RUN cycle.
      do_reset();
      push_exp("run_idle", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd0, 4'd0, 1'b0);
      tick();

      // Load-use variants.
      drive(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push_exp("lu_rs2", C_S, C_B, C_N, C_N, 1'b1, 1'b0, 2'd1, 4'd0, 4'd0, 1'b0);
      tick();
      idle();
      push_exp("lu_after", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd1, 4'd0, 1'b0);
      tick();
      drive(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push_exp("lu_x0", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd1, 4'd0, 1'b0);
      tick();
      drive(5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push_exp("lu_unused_src", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd1, 4'd0, 1'b0);
      tick();
      drive(5'd7, 1'b1, 5'd3, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      push_exp("lu_rs1", C_S, C_B, C_N, C_N, 1'b1, 1'b0, 2'd1, 4'd1, 4'd0, 1'b0);
      tick();
      drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push_exp("lu_not_load", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd2, 4'd0, 1'b0);
      tick();

      // Mispredict, alone and over a load-use.
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      push_exp("mispredict", C_B, C_B, C_N, C_N, 1'b0, 1'b1, 2'd1, 4'd2, 4'd0, 1'b0);
      tick();
      drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      push_exp("mp_over_lu", C_B, C_B, C_N, C_N, 1'b0, 1'b1, 2'd1, 4'd2, 4'd1, 1'b0);
      tick();
      idle();
      push_exp("mp_after", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd2, 4'd2, 1'b0);
      tick();

      // Memory wait of 4 cycles masking a mispredict.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         push_exp($sformatf("mwait_%0d", i), C_S, C_S, C_S, C_B, 1'b1, 1'b0,
                  (i == 0) ? 2'd1 : 2'd2, CW'(i), 4'd0, 1'b0);
         tick();
      end
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      push_exp("mwait_release", C_B, C_B, C_N, C_N, 1'b0, 1'b1, 2'd2, 4'd4, 4'd0, 1'b0);
      tick();
      idle();
      push_exp("mwait_after", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd4, 4'd1, 1'b1);
      tick();

      // Timeout: 6 not-ready cycles, flag rises after the 4th MWAIT cycle.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         push_exp($sformatf("tmo_wait_%0d", i), C_S, C_S, C_S, C_B, 1'b1, 1'b0,
                  (i == 0) ? 2'd1 : 2'd2, CW'(i), 4'd0, (i >= 5) ? 1'b1 : 1'b0);
         tick();
      end
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      push_exp("tmo_release", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd2, 4'd6, 4'd0, 1'b1);
      tick();
      idle();
      push_exp("tmo_sticky", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd6, 4'd0, 1'b1);
      tick();
      do_reset();
      push_exp("tmo_cleared", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd0, 4'd0, 1'b0);
      tick();

      // Counter saturation at all-ones.
      for (int k = 0; k < 17; k++) begin
         drive(5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         push_exp($sformatf("stall_sat_%0d", k), C_S, C_B, C_N, C_N, 1'b1, 1'b0, 2'd1,
                  (k > 15) ? 4'd15 : CW'(k), 4'd0, 1'b0);
         tick();
      end
      for (int k = 0; k < 17; k++) begin
         drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         push_exp($sformatf("flush_sat_%0d", k), C_B, C_B, C_N, C_N, 1'b0, 1'b1, 2'd1,
                  4'd15, (k > 15) ? 4'd15 : CW'(k), 1'b0);
         tick();
      end

      // Halt request ignored while in MWAIT.
      do_reset();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push_exp("hm_enter", C_S, C_S, C_S, C_B, 1'b1, 1'b0, 2'd1, 4'd0, 4'd0, 1'b0);
      tick();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      push_exp("hm_ignored", C_S, C_S, C_S, C_B, 1'b1, 1'b0, 2'd2, 4'd1, 4'd0, 1'b0);
      tick();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      push_exp("hm_release", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd2, 4'd2, 4'd0, 1'b0);
      tick();
      idle();
      push_exp("hm_run", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd2, 4'd0, 1'b0);
      tick();

      // Halt together with a memory wait in RUN: wait outputs, then HALT.
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      push_exp("halt_memwait", C_S, C_S, C_S, C_B, 1'b1, 1'b0, 2'd1, 4'd2, 4'd0, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(5'd6, 1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, k[0], 1'b0);
         push_exp($sformatf("halt_hold_%0d", k), C_S, C_S, C_S, C_S, 1'b1, 1'b0, 2'd3,
                  4'd3, 4'd0, 1'b0);
         tick();
      end

      // Reset asserted mid-HALT, then a plain halt from RUN.
      do_reset();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("halt_plain", C_N, C_N, C_N, C_N, 1'b0, 1'b0, 2'd1, 4'd0, 4'd0, 1'b0);
      tick();
      idle();
      push_exp("halt_state", C_S, C_S, C_S, C_S, 1'b1, 1'b0, 2'd3, 4'd0, 4'd0, 1'b0);
      tick();

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
